period_counter: RTL and testbench
=================================

Name: period_counter

Overview:
- Programmable up-counter instantiated twice beside accelerator_FSM: once as the low-bit counter (LCNT, WIDTH=5) and once as the high-bit counter (HCNT, WIDTH=3).
- Consumes the FSM's en/period/interrupt outputs and returns the ready flag the FSM branches on.
- Also reports the current count and a registered wrap pulse, used by datapath sequencing and debug.

Parameters:
- WIDTH, 5, bit width of count, period and interrupt values. Legal range 1..16.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- en_i  input  1  count enable; connects to LCNT_en_o / HCNT_en_o.
- period_i  input  WIDTH  terminal count; the counter runs 0..period_i inclusive.
- interrupt_i  input  WIDTH  compare value for ready_o.
- ready_o  output  1  high while the registered count equals interrupt_i; connects to LCNT_ready_i / HCNT_ready_i.
- cnt_o  output  WIDTH  current registered count.
- wrap_o  output  1  one-cycle registered pulse after a terminal-count rollover.

Behaviour:
- Registers:
  - cnt_q, WIDTH bits, reset 0.
  - period_q, WIDTH bits, reset all-ones.
  - wrap_q, 1 bit, reset 0.
- Reset:
  - rst_n low clears all registers asynchronously and immediately; release is synchronous to clk.
  - Output values in reset: cnt_o=0, wrap_o=0, ready_o=(interrupt_i==0).
  - Reset mid-count discards the count; no wrap pulse is generated.
- Config change detect: cfg_chg = (period_i != period_q). period_q <= period_i every cycle.
- cnt_q next-state, evaluated in priority order:
  1. cfg_chg=1 -> 0, regardless of en_i. This reload gives a clean restart when the FSM switches the period, e.g. 31 -> 16.
  2. en_i=1 and cnt_q==period_q -> 0 (rollover).
  3. en_i=1 -> cnt_q+1, unsigned, WIDTH bits.
  4. en_i=0 -> hold.
- cnt_q > period_q after a shortened period is impossible, because rule 1 reloads first.
- Sequence length: period_q+1 enabled cycles per wrap. With period_i=0, cnt stays 0 and every enabled cycle is a rollover.
- wrap_q <= (en_i and not cfg_chg and cnt_q==period_q). It pulses one cycle after the rollover edge and is never set while en_i=0.
- ready_o:
  - Combinational: ready_o = (cnt_q == interrupt_i). Zero latency from count and from interrupt_i.
  - Not gated by en_i, so the FSM can sample ready in the same cycle it enables a single HCNT step.
  - interrupt_i > period_i means ready_o never asserts. This is legal and not flagged.
- Simultaneous events:
  - cfg_chg and rollover in the same cycle: reload wins, wrap_q=0.
  - interrupt_i changing: ready_o follows combinationally; the count is unaffected.
- cnt_o = cnt_q, wrap_o = wrap_q.
- No internal state beyond the three registers; there are no illegal states.
- Asserts in bench:
  - cnt_q <= period_q whenever cfg_chg=0.
  - wrap_o never high on two consecutive cycles unless period_q==0.

Test Plan:
- Reset then basic count: rst_n low 3 cycles, interrupt_i=2, period_i=31 (no cfg_chg), en_i=1 -> cnt_o 0,1,2,...; ready_o high exactly while cnt_o=2; cnt_o=31 followed by 0; wrap_o high the cycle cnt_o shows 0.
- Period switch: count to 5 with period 31, then period_i=16 -> next cnt_o=0 even with en_i=1; count 0..16 then rollover; wrap_o pulses every 17 enabled cycles.
- Enable gating: period_i=16, en_i toggled 1,0,0,1 -> cnt_o holds during en_i=0; no wrap_o during hold; ready_o at interrupt_i=16 stays high while holding at 16.
- HCNT usage (WIDTH=3): period_i=7, interrupt_i=7, en_i single-cycle pulses -> cnt_o steps once per pulse; ready_o high after the 7th pulse and in the cycle of the 8th pulse; the 8th pulse rolls to 0 with wrap_o=1 next cycle.
- Edge cases: period_i=0 with en_i=1 -> cnt_o stays 0 and wrap_o high every cycle after the first; interrupt_i=5 > period_i=3 -> ready_o never asserts.
- Async reset mid-run: assert rst_n between clock edges at cnt_o=9 -> cnt_o=0 and wrap_o=0 immediately; after release with an unchanged period_i=31, counting resumes from 0 on the first enabled edge.

Source files
------------

// File: rtl/period_counter.sv
// Programmable up-counter: runs 0..period_i while enabled, restarts cleanly on a
// period change, and reports count, compare-match ready and a registered wrap pulse.
module period_counter #(
   parameter int WIDTH = 5
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en_i,
   input  logic [WIDTH-1:0] period_i,
   input  logic [WIDTH-1:0] interrupt_i,
   output logic             ready_o,
   output logic [WIDTH-1:0] cnt_o,
   output logic             wrap_o
);

   logic [WIDTH-1:0] cnt_q;
   logic [WIDTH-1:0] period_q;
   logic             wrap_q;

   logic [WIDTH-1:0] cnt_d;
   logic             wrap_d;
   logic             cfg_chg;
   logic             at_term;

   assign cfg_chg = (period_i != period_q);
   assign at_term = (cnt_q == period_q);

   // Next count and wrap; a period change outranks a rollover in the same cycle.
   always_comb begin
      cnt_d  = cnt_q;
      wrap_d = 1'b0;
      if (cfg_chg) begin
         cnt_d  = {WIDTH{1'b0}};
         wrap_d = 1'b0;
      end else if (en_i) begin
         if (at_term) begin
            cnt_d  = {WIDTH{1'b0}};
            wrap_d = 1'b1;
         end else begin
            cnt_d  = cnt_q + WIDTH'(1'b1);
            wrap_d = 1'b0;
         end
      end else begin
         cnt_d  = cnt_q;
         wrap_d = 1'b0;
      end
   end

   // State registers; period_q resets to all-ones so the full-range period needs no reload.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q    <= {WIDTH{1'b0}};
         period_q <= {WIDTH{1'b1}};
         wrap_q   <= 1'b0;
      end else begin
         cnt_q    <= cnt_d;
         period_q <= period_i;
         wrap_q   <= wrap_d;
      end
   end

   // ready is deliberately not gated by en_i so a single-step enable can see it.
   assign ready_o = (cnt_q == interrupt_i);
   assign cnt_o   = cnt_q;
   assign wrap_o  = wrap_q;

endmodule

// File: tb/tb_period_counter.sv
// Randomized bench for period_counter: a 5-bit (LCNT) and a 3-bit (HCNT) instance
// checked every cycle against a modular-arithmetic reference model.
module tb_period_counter;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;

   logic       en_l = 1'b0;
   logic [4:0] per_l = 5'd31;
   logic [4:0] int_l = 5'd0;
   logic       ready_l;
   logic [4:0] cnt_l;
   logic       wrap_l;

   logic       en_h = 1'b0;
   logic [2:0] per_h = 3'd7;
   logic [2:0] int_h = 3'd0;
   logic       ready_h;
   logic [2:0] cnt_h;
   logic       wrap_h;

   int n_checks = 0;
   int n_errors = 0;

   // reference model state
   int  ml_cnt, ml_per, mh_cnt, mh_per;
   bit  ml_wrap, mh_wrap;
   bit  ml_chg, mh_chg;
   bit  prev_wrap_l, prev_wrap_h;

   period_counter #(.WIDTH(5)) dut_l (
      .clk(clk), .rst_n(rst_n), .en_i(en_l), .period_i(per_l),
      .interrupt_i(int_l), .ready_o(ready_l), .cnt_o(cnt_l), .wrap_o(wrap_l)
   );

   period_counter #(.WIDTH(3)) dut_h (
      .clk(clk), .rst_n(rst_n), .en_i(en_h), .period_i(per_h),
      .interrupt_i(int_h), .ready_o(ready_h), .cnt_o(cnt_h), .wrap_o(wrap_h)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s actual=%0d expected=%0d at %0t", tag, act, exp, $time);
      end
   endtask

   // One clock of the counter described as a modular sequence of length per+1.
   task automatic model(input bit en, input int pin, input int cnt, input int per,
                        output int ncnt, output int nper, output bit nwrap);
      if (pin != per) begin
         ncnt  = 0;
         nwrap = 1'b0;
      end else if (en) begin
         ncnt  = (cnt + 1) % (per + 1);
         nwrap = (cnt == per);
      end else begin
         ncnt  = cnt;
         nwrap = 1'b0;
      end
      nper = pin;
   endtask

   task automatic model_reset();
      ml_cnt = 0; ml_per = 31; ml_wrap = 1'b0;
      mh_cnt = 0; mh_per = 7;  mh_wrap = 1'b0;
   endtask

   task automatic compare_all();
      check("cnt_l",   cnt_l,   ml_cnt);
      check("wrap_l",  wrap_l,  ml_wrap);
      check("ready_l", ready_l, (ml_cnt == int'(int_l)));
      check("cnt_h",   cnt_h,   mh_cnt);
      check("wrap_h",  wrap_h,  mh_wrap);
      check("ready_h", ready_h, (mh_cnt == int'(int_h)));
      ml_chg = (int'(per_l) != ml_per);
      mh_chg = (int'(per_h) != mh_per);
      if (!ml_chg) check("bound_l", (int'(cnt_l) <= ml_per), 1'b1);
      if (!mh_chg) check("bound_h", (int'(cnt_h) <= mh_per), 1'b1);
      if (ml_per != 0) check("dblwrap_l", (wrap_l && prev_wrap_l), 1'b0);
      if (mh_per != 0) check("dblwrap_h", (wrap_h && prev_wrap_h), 1'b0);
      prev_wrap_l = wrap_l;
      prev_wrap_h = wrap_h;
   endtask

   task automatic step();
      @(posedge clk);
      if (!rst_n) begin
         model_reset();
      end else begin
         model(en_l, int'(per_l), ml_cnt, ml_per, ml_cnt, ml_per, ml_wrap);
         model(en_h, int'(per_h), mh_cnt, mh_per, mh_cnt, mh_per, mh_wrap);
      end
      #1;
      compare_all();
   endtask

   initial begin
      int guard;
      model_reset();
      prev_wrap_l = 1'b0;
      prev_wrap_h = 1'b0;

      // reset state, ready tracks interrupt_i==0 while held
      #1;
      check("rst_cnt",   cnt_l, 5'd0);
      check("rst_wrap",  wrap_l, 1'b0);
      check("rst_ready0", ready_l, 1'b1);
      int_l = 5'd2;
      #1;
      check("rst_ready2", ready_l, 1'b0);
      en_l = 1'b1;
      repeat (3) step();
      rst_n = 1'b1;

      // basic count through a full 0..31 cycle and rollover
      repeat (40) step();

      // period switch 31 -> 16 mid-count
      per_l = 5'd31;
      guard = 0;
      while (ml_cnt != 5 && guard < 64) begin step(); guard++; end
      check("reach5", cnt_l, 5'd5);
      per_l = 5'd16;
      step();
      check("reload", cnt_l, 5'd0);
      repeat (40) step();

      // enable gating with ready held at 16
      int_l = 5'd16;
      guard = 0;
      while (ml_cnt != 15 && guard < 64) begin step(); guard++; end
      for (int k = 0; k < 12; k++) begin
         en_l = (k % 4 == 0) || (k % 4 == 3);
         step();
      end
      en_l = 1'b1;
      guard = 0;
      while (ml_cnt != 16 && guard < 64) begin step(); guard++; end
      en_l = 1'b0;
      repeat (3) step();
      check("hold16_ready", ready_l, 1'b1);
      check("hold16_cnt", cnt_l, 5'd16);

      // HCNT single-step pulses, period 7, interrupt 7
      per_h = 3'd7; int_h = 3'd7;
      step();
      guard = 0;
      while (mh_cnt != 0 && guard < 32) begin en_h = 1'b1; step(); en_h = 1'b0; step(); guard++; end
      for (int p = 1; p <= 8; p++) begin
         en_h = 1'b1;
         if (p == 8) check("h_ready_pulse8", ready_h, 1'b1);
         step();
         en_h = 1'b0;
         step();
         step();
      end
      check("h_after8", cnt_h, 3'd0);

      // period 0: count pinned, wrap every enabled cycle
      per_l = 5'd0; en_l = 1'b1; int_l = 5'd0;
      per_h = 3'd0; en_h = 1'b1; int_h = 3'd0;
      repeat (6) step();
      check("p0_wrap", wrap_l, 1'b1);

      // interrupt beyond period never matches
      per_l = 5'd3; int_l = 5'd5;
      per_h = 3'd3; int_h = 3'd5;
      repeat (12) step();

      // randomized traffic
      for (int i = 0; i < 400; i++) begin
         en_l = $urandom_range(0, 3) != 0;
         en_h = $urandom_range(0, 2) == 0;
         if ($urandom_range(0, 15) == 0) per_l = 5'($urandom_range(0, 31));
         if ($urandom_range(0, 15) == 0) per_h = 3'($urandom_range(0, 7));
         if ($urandom_range(0, 7) == 0)  int_l = 5'($urandom_range(0, 31));
         if ($urandom_range(0, 7) == 0)  int_h = 3'($urandom_range(0, 7));
         step();
      end

      // asynchronous reset between edges at count 9
      per_l = 5'd31; en_l = 1'b1; int_l = 5'd9;
      per_h = 3'd7;  en_h = 1'b0;
      guard = 0;
      while (ml_cnt != 9 && guard < 100) begin step(); guard++; end
      check("reach9", cnt_l, 5'd9);
      #3;
      rst_n = 1'b0;
      #1;
      model_reset();
      check("arst_cnt",  cnt_l, 5'd0);
      check("arst_wrap", wrap_l, 1'b0);
      check("arst_cnt_h", cnt_h, 3'd0);
      repeat (2) step();
      rst_n = 1'b1;
      step();
      check("resume1", cnt_l, 5'd1);
      repeat (10) step();

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
